// File: rtl/mps_precharge_sequencer.sv
// DC-link power-path sequencer: precharge -> main contactor -> ready, and the
// orderly PWM-stop / discharge path back to idle, with a latched fail cause.
module mps_precharge_sequencer #(
  parameter logic [31:0] PRECHG_TIMEOUT = 32'd200_000_000,
  parameter logic [31:0] MC_SETTLE      = 32'd20_000_000,
  parameter logic [31:0] PWM_STOP_DLY   = 32'd200_000,
  parameter logic [31:0] DISCHG_TIMEOUT = 32'd1_000_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_on_req,
  input  logic        i_off_req,
  input  logic        i_fault_clr,
  input  logic        i_intl,
  input  logic [31:0] i_dc_v,
  input  logic [31:0] i_prechg_th,
  input  logic [31:0] i_dischg_th,
  input  logic [2:0]  i_mc_fb,
  output logic [2:0]  o_mc,
  output logic        o_pwm_en,
  output logic        o_ready,
  output logic        o_busy,
  output logic [3:0]  o_state,
  output logic [3:0]  o_fail_code
);

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_PRECHG      = 4'd1,
    S_MAIN_CLOSE  = 4'd2,
    S_PRECHG_OPEN = 4'd3,
    S_READY       = 4'd4,
    S_OPENING     = 4'd5,
    S_DISCHG      = 4'd6,
    S_FAULT       = 4'd7
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] timer;
  logic [3:0]  code_nxt;
  logic        powered;
  logic        unused_fb;

  // The discharge relay feedback is not needed for any decision.
  assign unused_fb = i_mc_fb[2];
  assign powered   = (state != S_IDLE) && (state != S_DISCHG) && (state != S_FAULT);
  assign o_state   = state;

  function automatic logic [2:0] mc_decode(state_t s);
    case (s)
      S_PRECHG:      return 3'b001;
      S_MAIN_CLOSE:  return 3'b011;
      S_PRECHG_OPEN: return 3'b010;
      S_READY:       return 3'b010;
      S_OPENING:     return 3'b010;
      S_DISCHG:      return 3'b100;
      S_FAULT:       return 3'b100;
      default:       return 3'b000;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    code_nxt  = o_fail_code;
    if (powered && i_intl) begin
      state_nxt = S_FAULT;
      code_nxt  = 4'd1;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_on_req) begin
            if (i_intl) begin
              state_nxt = S_FAULT;
              code_nxt  = 4'd1;
            end else begin
              state_nxt = S_PRECHG;
            end
          end
        end
        S_PRECHG: begin
          if (i_off_req) begin
            state_nxt = S_DISCHG;
          end else if (timer >= MC_SETTLE && i_dc_v >= i_prechg_th) begin
            state_nxt = S_MAIN_CLOSE;
          end else if (timer >= PRECHG_TIMEOUT) begin
            state_nxt = S_FAULT;
            code_nxt  = 4'd2;
          end
        end
        S_MAIN_CLOSE: begin
          if (i_off_req) begin
            state_nxt = S_DISCHG;
          end else if (timer >= MC_SETTLE) begin
            if (i_mc_fb[1]) begin
              state_nxt = S_PRECHG_OPEN;
            end else begin
              state_nxt = S_FAULT;
              code_nxt  = 4'd3;
            end
          end
        end
        S_PRECHG_OPEN: begin
          if (i_off_req) begin
            state_nxt = S_DISCHG;
          end else if (timer >= MC_SETTLE) begin
            if (i_mc_fb[1:0] == 2'b10) begin
              state_nxt = S_READY;
            end else begin
              state_nxt = S_FAULT;
              code_nxt  = 4'd3;
            end
          end
        end
        S_READY: begin
          if (i_off_req) begin
            state_nxt = S_OPENING;
          end else if (!i_mc_fb[1]) begin
            state_nxt = S_FAULT;
            code_nxt  = 4'd4;
          end
        end
        S_OPENING: begin
          if (timer >= PWM_STOP_DLY) state_nxt = S_DISCHG;
        end
        S_DISCHG: begin
          if (i_dc_v <= i_dischg_th) begin
            state_nxt = S_IDLE;
          end else if (timer >= DISCHG_TIMEOUT) begin
            state_nxt = S_FAULT;
            code_nxt  = 4'd5;
          end
        end
        S_FAULT: begin
          // Interlock is ignored here, so the first latched cause survives.
          if (i_fault_clr && !i_intl && i_dc_v <= i_dischg_th) begin
            state_nxt = S_IDLE;
            code_nxt  = 4'd0;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= S_IDLE;
      timer       <= '0;
      o_mc        <= 3'b000;
      o_pwm_en    <= 1'b0;
      o_ready     <= 1'b0;
      o_busy      <= 1'b0;
      o_fail_code <= 4'd0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        timer <= '0;
      end else if (timer != '1) begin
        timer <= timer + 32'd1;
      end
      o_mc        <= mc_decode(state_nxt);
      o_pwm_en    <= (state_nxt == S_READY);
      o_ready     <= (state_nxt == S_READY);
      o_busy      <= state_nxt inside {S_PRECHG, S_MAIN_CLOSE, S_PRECHG_OPEN, S_OPENING, S_DISCHG};
      o_fail_code <= code_nxt;
    end
  end

endmodule

// File: tb/tb_mps_precharge_sequencer.sv
// Scoreboard bench for mps_precharge_sequencer: a behavioural model queues the
// expected state transitions; a monitor pops them and checks every output.
module tb_mps_precharge_sequencer;
  localparam int IDLE = 0, PRECHG = 1, MAINC = 2, POPEN = 3;
  localparam int READY = 4, OPENING = 5, DISCHG = 6, FAULT = 7;
  localparam int PT = 100, MS = 10, PD = 4, DT = 100;

  logic        clk = 1'b0;
  logic        rst, on_req, off_req, fault_clr, intl;
  logic [31:0] dc_v, prechg_th, dischg_th;
  logic [2:0]  mc_fb, mc;
  logic        pwm_en, ready, busy;
  logic [3:0]  state, fail_code;

  mps_precharge_sequencer #(
    .PRECHG_TIMEOUT(32'd100), .MC_SETTLE(32'd10),
    .PWM_STOP_DLY(32'd4), .DISCHG_TIMEOUT(32'd100)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_on_req(on_req), .i_off_req(off_req),
    .i_fault_clr(fault_clr), .i_intl(intl), .i_dc_v(dc_v),
    .i_prechg_th(prechg_th), .i_dischg_th(dischg_th), .i_mc_fb(mc_fb),
    .o_mc(mc), .o_pwm_en(pwm_en), .o_ready(ready), .o_busy(busy),
    .o_state(state), .o_fail_code(fail_code)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int st; int code; } rec_t;
  rec_t q[$];
  rec_t r;
  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int m_st = 0, m_tmr = 0, m_code = 0;
  int exp_st = 0, exp_code = 0, prev_st = 0;
  logic [2:0] fb_d1 = 3'b000, fb_d2 = 3'b000, stuck0 = 3'b000, stuck1 = 3'b000;

  function automatic logic [2:0] mc_of(int s);
    case (s)
      PRECHG:              return 3'b001;
      MAINC:               return 3'b011;
      POPEN, READY, OPENING: return 3'b010;
      DISCHG, FAULT:       return 3'b100;
      default:             return 3'b000;
    endcase
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one step per clock, using the inputs present at the edge.
  task automatic model_step();
    int n = m_st;
    int c = m_code;
    bit powered = !(m_st inside {IDLE, DISCHG, FAULT});
    if (powered && intl) begin n = FAULT; c = 1; end
    else case (m_st)
      IDLE:    if (on_req) begin if (intl) begin n = FAULT; c = 1; end else n = PRECHG; end
      PRECHG:  if (off_req) n = DISCHG;
               else if (m_tmr >= MS && dc_v >= prechg_th) n = MAINC;
               else if (m_tmr >= PT) begin n = FAULT; c = 2; end
      MAINC:   if (off_req) n = DISCHG;
               else if (m_tmr >= MS) begin if (mc_fb[1]) n = POPEN; else begin n = FAULT; c = 3; end end
      POPEN:   if (off_req) n = DISCHG;
               else if (m_tmr >= MS) begin if (mc_fb[1:0] == 2'b10) n = READY; else begin n = FAULT; c = 3; end end
      READY:   if (off_req) n = OPENING; else if (!mc_fb[1]) begin n = FAULT; c = 4; end
      OPENING: if (m_tmr >= PD) n = DISCHG;
      DISCHG:  if (dc_v <= dischg_th) n = IDLE; else if (m_tmr >= DT) begin n = FAULT; c = 5; end
      FAULT:   if (fault_clr && !intl && dc_v <= dischg_th) begin n = IDLE; c = 0; end
      default: n = IDLE;
    endcase
    if (n != m_st) begin
      q.push_back('{cyc + 1, n, c});
      m_tmr = 0;
    end else begin
      m_tmr++;
    end
    m_st = n;
    m_code = c;
  endtask

  // Contactor feedback follows the expected drive two cycles late, with stuck masks.
  task automatic tick();
    mc_fb = (fb_d2 & ~stuck0) | stuck1;
    fb_d2 = fb_d1;
    fb_d1 = mc_of(m_st);
    model_step();
    @(negedge clk);
    #1;
    on_req = 1'b0; off_req = 1'b0; fault_clr = 1'b0;
  endtask

  task automatic wait_state(int s, int maxc);
    int n = 0;
    while (m_st != s && n < maxc) begin tick(); n++; end
    if (n >= maxc) check("wait_state_timeout", m_st, s);
  endtask

  task automatic model_reset();
    q.delete();
    m_st = 0; m_tmr = 0; m_code = 0;
    exp_st = 0; exp_code = 0; prev_st = 0;
    fb_d1 = 3'b000; fb_d2 = 3'b000;
  endtask

  function automatic logic [31:0] pick_v();
    case ($urandom_range(0, 9))
      0: return 32'd49;
      1: return 32'd50;
      2: return 32'd51;
      3: return 32'd899;
      4: return 32'd900;
      5: return 32'd901;
      6: return 32'hFFFF_0000;
      default: return 32'($urandom_range(0, 2000));
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (int'(state) != prev_st || (q.size() > 0 && q[0].cyc <= cyc)) begin
        if (q.size() == 0) begin
          check("unexpected_transition", int'(state), prev_st);
        end else begin
          r = q.pop_front();
          check("transition_cycle", cyc, r.cyc);
          exp_st = r.st;
          exp_code = r.code;
        end
        prev_st = int'(state);
      end
      check("state", int'(state), exp_st);
      check("mc", int'(mc), int'(mc_of(exp_st)));
      check("pwm_en", int'(pwm_en), int'(exp_st == READY));
      check("ready", int'(ready), int'(exp_st == READY));
      check("busy", int'(busy), int'(exp_st inside {PRECHG, MAINC, POPEN, OPENING, DISCHG}));
      check("fail_code", int'(fail_code), exp_code);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; on_req = 1'b0; off_req = 1'b0; fault_clr = 1'b0; intl = 1'b0;
    dc_v = 32'd0; prechg_th = 32'd900; dischg_th = 32'd50; mc_fb = 3'b000;
    repeat (3) @(negedge clk);
    #1;
    check("reset_state", int'(state), 0);
    check("reset_mc", int'(mc), 0);
    check("reset_pwm", int'(pwm_en), 0);
    check("reset_code", int'(fail_code), 0);
    model_reset();
    rst = 1'b0;
    repeat (3) tick();

    // nominal on, then nominal off
    dc_v = 32'd1000; on_req = 1'b1; tick();
    wait_state(READY, 100);
    on_req = 1'b1; tick();
    repeat (4) tick();
    off_req = 1'b1; tick();
    wait_state(DISCHG, 20);
    repeat (3) tick();
    dc_v = 32'd40; tick();
    wait_state(IDLE, 5);

    // precharge timeout, clear at the discharge threshold boundary
    dc_v = 32'd500; on_req = 1'b1; tick();
    wait_state(FAULT, 200);
    repeat (3) tick();
    dc_v = 32'd50; fault_clr = 1'b1; tick();
    wait_state(IDLE, 5);

    // main contactor feedback stuck open; clear refused above threshold
    dc_v = 32'd1000; stuck0 = 3'b010; on_req = 1'b1; tick();
    wait_state(FAULT, 100);
    dc_v = 32'd60; fault_clr = 1'b1; tick();
    repeat (2) tick();
    dc_v = 32'd40; fault_clr = 1'b1; tick();
    stuck0 = 3'b000;
    wait_state(IDLE, 5);

    // precharge contactor stuck closed at PRECHG_OPEN check
    dc_v = 32'd900; stuck1 = 3'b001; on_req = 1'b1; tick();
    wait_state(FAULT, 100);
    stuck1 = 3'b000; dc_v = 32'd40; fault_clr = 1'b1; tick();
    wait_state(IDLE, 5);

    // interlock in READY; later interlock and clears while interlocked
    dc_v = 32'd1000; on_req = 1'b1; tick();
    wait_state(READY, 100);
    repeat (3) tick();
    intl = 1'b1; tick();
    repeat (3) tick();
    dc_v = 32'd40; fault_clr = 1'b1; tick();
    intl = 1'b0; tick();
    intl = 1'b1; tick();
    intl = 1'b0; tick();
    fault_clr = 1'b1; tick();
    wait_state(IDLE, 5);

    // interlock with on request in IDLE; simultaneous on/off in IDLE
    intl = 1'b1; on_req = 1'b1; tick();
    intl = 1'b0; fault_clr = 1'b1; tick();
    wait_state(IDLE, 5);
    dc_v = 32'd1000; on_req = 1'b1; off_req = 1'b1; tick();
    repeat (3) tick();
    off_req = 1'b1; tick();
    repeat (2) tick();
    dc_v = 32'd40; tick();
    wait_state(IDLE, 5);

    // off during MAIN_CLOSE, then discharge timeout
    dc_v = 32'd1000; on_req = 1'b1; tick();
    wait_state(MAINC, 50);
    off_req = 1'b1; tick();
    on_req = 1'b1; tick();
    wait_state(FAULT, 200);
    dc_v = 32'd40; fault_clr = 1'b1; tick();
    wait_state(IDLE, 5);

    // feedback loss in READY
    dc_v = 32'd1000; on_req = 1'b1; tick();
    wait_state(READY, 100);
    stuck0 = 3'b010;
    wait_state(FAULT, 10);
    stuck0 = 3'b000; dc_v = 32'd40; fault_clr = 1'b1; tick();
    wait_state(IDLE, 5);

    // asynchronous reset in MAIN_CLOSE
    dc_v = 32'd1000; on_req = 1'b1; tick();
    wait_state(MAINC, 50);
    repeat (2) tick();
    rst = 1'b1;
    #1;
    check("async_rst_mc", int'(mc), 0);
    check("async_rst_pwm", int'(pwm_en), 0);
    check("async_rst_state", int'(state), 0);
    model_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (2) tick();

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      on_req    = ($urandom_range(0, 99) < 6);
      off_req   = ($urandom_range(0, 99) < 3);
      fault_clr = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 199) == 0) intl = ~intl;
      if ($urandom_range(0, 29) == 0) dc_v = pick_v();
      if ($urandom_range(0, 149) == 0) begin
        stuck0 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
        stuck1 = ($urandom_range(0, 5) == 0) ? 3'b001 : 3'b000;
      end
      tick();
    end
    intl = 1'b0;
    repeat (3) tick();
    check("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mps_precharge_sequencer.md
Name: mps_precharge_sequencer

Overview:
Sequences the MPS DC-link power path: precharge contactor, main contactor, discharge relay and the PWM enable.
- Sits between the system FSM and the magnetic-contactor outputs of the MPS system top.
- Consumes the on/off requests, the combined interlock flag, the DC-link voltage and the contactor auxiliary feedback.
- Detects precharge, contactor and discharge failures and latches a fail code for AXI readback.

Parameters:
PRECHG_TIMEOUT, 200000000, max cycles in PRECHG before fault (1 s at 200 MHz)
MC_SETTLE, 20000000, contactor settle/dwell cycles (100 ms)
PWM_STOP_DLY, 200000, cycles PWM is off before the main contactor opens (1 ms)
DISCHG_TIMEOUT, 1000000000, max cycles in DISCHG before fault (5 s)

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset; one clock; reset is asynchronous and active-high
i_on_req  in  1  single-cycle power-on request
i_off_req  in  1  single-cycle power-off request
i_fault_clr  in  1  single-cycle fault clear
i_intl  in  1  combined interlock flag (level)
i_dc_v  in  32  DC-link voltage, unsigned
i_prechg_th  in  32  precharge-complete threshold, unsigned
i_dischg_th  in  32  discharge-complete threshold, unsigned
i_mc_fb  in  3  aux feedback: [0] precharge, [1] main, [2] discharge
o_mc  out  3  contactor drive: [0] precharge, [1] main, [2] discharge
o_pwm_en  out  1  PWM enable
o_ready  out  1  high only in READY
o_busy  out  1  high in PRECHG, MAIN_CLOSE, PRECHG_OPEN, OPENING, DISCHG
o_state  out  4  current state code
o_fail_code  out  4  latched fail cause; 0 = none

Behaviour:
- Reset values:
  - state IDLE; all outputs 0; timer 0.
- States and codes; output values per state:
  - IDLE=0: o_mc 000.
  - PRECHG=1: o_mc 001.
  - MAIN_CLOSE=2: o_mc 011.
  - PRECHG_OPEN=3: o_mc 010.
  - READY=4: o_mc 010, o_pwm_en 1.
  - OPENING=5: o_mc 010, o_pwm_en 0.
  - DISCHG=6: o_mc 100.
  - FAULT=7: o_mc 100.
- Output timing: all outputs are registered and decoded from the next state, so they change on the same edge as o_state.
- Timer:
  - 32-bit counter, cleared on every state change, otherwise increments.
  - Saturates at all-ones.
  - All comparisons are unsigned, against the timer value before the increment.
- Event priority per cycle: i_intl > i_off_req > i_on_req > timer/threshold conditions.
- Interlock: i_intl=1 in any state except IDLE, DISCHG or FAULT -> FAULT, code 1. o_pwm_en and o_mc[1:0] drop on that same edge.
- IDLE:
  - i_on_req with i_intl=1 -> FAULT, code 1.
  - i_on_req with i_intl=0 -> PRECHG.
  - i_off_req is ignored.
- PRECHG:
  - timer>=MC_SETTLE and i_dc_v>=i_prechg_th -> MAIN_CLOSE.
  - Otherwise, timer>=PRECHG_TIMEOUT -> FAULT, code 2.
- MAIN_CLOSE: at timer>=MC_SETTLE, if i_mc_fb[1]=1 -> PRECHG_OPEN, else FAULT, code 3.
- PRECHG_OPEN: at timer>=MC_SETTLE, if i_mc_fb[1:0]=10 -> READY, else FAULT, code 3.
- READY:
  - i_mc_fb[1]=0 -> FAULT, code 4.
  - i_off_req -> OPENING.
  - i_on_req is ignored.
- OPENING: at timer>=PWM_STOP_DLY -> DISCHG.
- Off request mid-sequence: i_off_req in PRECHG, MAIN_CLOSE or PRECHG_OPEN aborts directly to DISCHG (PWM is never enabled there).
- DISCHG:
  - i_dc_v<=i_dischg_th -> IDLE.
  - Otherwise, timer>=DISCHG_TIMEOUT -> FAULT, code 5.
  - i_on_req is ignored.
- FAULT:
  - o_fail_code is held; only the first cause is latched.
  - i_fault_clr with i_intl=0 and i_dc_v<=i_dischg_th -> IDLE, code cleared to 0.
  - Otherwise i_fault_clr is ignored.
- Simultaneous i_on_req and i_off_req in IDLE: i_on_req wins (off is ignored in IDLE).
- Reset mid-operation: immediate return to reset values, including o_mc=000 asynchronously.

Test Plan:
(Bench overrides PRECHG_TIMEOUT=100, MC_SETTLE=10, PWM_STOP_DLY=4, DISCHG_TIMEOUT=100; thresholds prechg_th=900, dischg_th=50.)
- Nominal on: on_req with dc_v=1000 and mc_fb following o_mc after 2 cycles -> states 1,2,3,4; PRECHG lasts 11 cycles; o_pwm_en=1 and o_ready=1 in READY.
- Nominal off: from READY, off_req -> OPENING 5 cycles with pwm 0 and mc 010; then DISCHG with mc 100; dc_v set to 40 -> IDLE, mc 000.
- Precharge timeout: dc_v held at 500 -> FAULT after 101 cycles in PRECHG; fail_code 2; mc 100.
- Contactor fail: mc_fb[1] stuck 0 -> FAULT, code 3, at the MAIN_CLOSE settle check; fault_clr with dc_v=40 -> IDLE, code 0.
- Interlock in READY: intl=1 -> next edge pwm 0, mc 100, code 1. A later intl during FAULT must not overwrite the code. fault_clr while intl=1 is ignored.
- Async reset asserted in MAIN_CLOSE -> o_mc=000 and o_pwm_en=0 before the next clock edge; o_state=0.
